// File: rtl/audio_sample_feeder.sv
`default_nettype none
// ============================================================================
// Module  : audio_sample_feeder
// Purpose : Paces FIFO-buffered samples into the FIR at FS_HZ using a phase
//           accumulator, issuing one rfd-qualified nd strobe per tick.
// Revision: 1.0 - initial release
// ============================================================================
module audio_sample_feeder #(
  parameter int DATA_W     = 16,
  parameter int CLK_HZ     = 50_000_000,
  parameter int FS_HZ      = 44_100,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            enable,
  input  logic [DATA_W-1:0]               src_data,
  input  logic                            src_valid,
  output logic                            src_ready,
  input  logic                            fir_rfd,
  output logic [DATA_W-1:0]               fir_din,
  output logic                            fir_nd,
  output logic                            sample_tick,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic [15:0]                     underrun_cnt,
  output logic [15:0]                     late_cnt
);

  localparam int ACC_W = $clog2(CLK_HZ) + 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [ACC_W-1:0] c_fs    = ACC_W'(FS_HZ);
  localparam logic [ACC_W-1:0] c_clk   = ACC_W'(CLK_HZ);
  localparam logic [LVL_W-1:0] c_depth = LVL_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_TICK = 2'd1,
    S_WAIT_RFD  = 2'd2,
    S_ISSUE     = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [DATA_W-1:0]   pending_q, pending_d;
  logic [DATA_W-1:0]   din_q, din_d;
  logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]    level_q, level_d;
  logic                ready_q;
  logic [15:0]         under_q, late_q;

  logic [ACC_W-1:0]    w_acc_sum;
  logic                w_tick;
  logic                w_push;
  logic                w_pop;
  logic                w_empty;
  logic                w_under_inc;
  logic                w_late_inc;

  // The sum never overflows ACC_W since both acc and FS_HZ are below CLK_HZ.
  assign w_acc_sum = acc_q + c_fs;
  assign w_tick    = !rst && enable && (w_acc_sum >= c_clk);
  assign w_empty   = (level_q == '0);
  assign w_push    = src_valid && ready_q;

  always_comb begin
    acc_d = acc_q;
    if (enable) acc_d = w_tick ? (w_acc_sum - c_clk) : w_acc_sum;
  end

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    din_d       = din_q;
    w_pop       = 1'b0;
    w_under_inc = 1'b0;
    w_late_inc  = 1'b0;
    if (!enable) begin
      state_d   = S_IDLE;
      pending_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE: state_d = S_WAIT_TICK;
        S_WAIT_TICK: begin
          if (w_tick) begin
            if (!w_empty) begin
              pending_d = mem_q[rd_ptr_q];
              w_pop     = 1'b1;
            end else begin
              pending_d   = '0;
              w_under_inc = 1'b1;
            end
            if (fir_rfd) begin
              state_d = S_ISSUE;
              din_d   = pending_d;
            end else begin
              state_d = S_WAIT_RFD;
            end
          end
        end
        S_WAIT_RFD: begin
          w_late_inc = w_tick;
          if (fir_rfd) begin
            state_d = S_ISSUE;
            din_d   = pending_q;
          end
        end
        S_ISSUE: state_d = S_WAIT_TICK;
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign level_d = level_q + {{(LVL_W-1){1'b0}}, w_push} - {{(LVL_W-1){1'b0}}, w_pop};

  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q] <= src_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      pending_q <= '0;
      din_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      ready_q   <= 1'b0;
      under_q   <= '0;
      late_q    <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      pending_q <= pending_d;
      din_q     <= din_d;
      level_q   <= level_d;
      ready_q   <= (level_d != c_depth);
      if (w_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (w_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (w_under_inc && (under_q != 16'hFFFF)) under_q <= under_q + 16'd1;
      if (w_late_inc && (late_q != 16'hFFFF))   late_q  <= late_q + 16'd1;
    end
  end

  assign src_ready    = ready_q;
  assign fir_din      = din_q;
  assign fir_nd       = (state_q == S_ISSUE);
  assign sample_tick  = w_tick;
  assign fifo_level   = level_q;
  assign underrun_cnt = under_q;
  assign late_cnt     = late_q;

endmodule
`default_nettype wire

// File: tb/tb_audio_sample_feeder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_audio_sample_feeder
// Purpose : Directed self-checking bench with an output scoreboard and a
//           reference phase accumulator for the pacing strobe.
// Revision: 1.0 - initial release
// ============================================================================
module tb_audio_sample_feeder;

  localparam int DW    = 16;
  localparam int CLKHZ = 10;
  localparam int FSHZ  = 3;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic [DW-1:0] src_data;
  logic          src_valid;
  logic          src_ready;
  logic          fir_rfd;
  logic [DW-1:0] fir_din;
  logic          fir_nd;
  logic          sample_tick;
  logic [3:0]    fifo_level;
  logic [15:0]   underrun_cnt;
  logic [15:0]   late_cnt;

  int            n_total = 0;
  int            n_pass  = 0;
  logic [DW-1:0] exp_q[$];
  int            macc    = 0;

  always #5 clk = ~clk;

  audio_sample_feeder #(
    .DATA_W(DW), .CLK_HZ(CLKHZ), .FS_HZ(FSHZ), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
    .fir_rfd(fir_rfd), .fir_din(fir_din), .fir_nd(fir_nd),
    .sample_tick(sample_tick), .fifo_level(fifo_level),
    .underrun_cnt(underrun_cnt), .late_cnt(late_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Reference pacing model plus scoreboard push (on accept) and pop (on nd).
  always @(negedge clk) begin
    logic exp_tick;
    exp_tick = !rst && enable && (macc + FSHZ >= CLKHZ);
    check("sample_tick", 32'(sample_tick), 32'(exp_tick));
    if (rst) macc = 0;
    else if (enable) macc = exp_tick ? macc + FSHZ - CLKHZ : macc + FSHZ;
    if (rst) begin
      exp_q.delete();
    end else begin
      if (fir_nd) begin
        check("nd_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("fir_din", 32'(fir_din), 32'(exp_q.pop_front()));
      end
      if (src_valid && src_ready) exp_q.push_back(src_data);
    end
  end

  task automatic push(input logic [DW-1:0] d);
    bit done;
    done      = 1'b0;
    src_data  = d;
    src_valid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (src_ready) done = 1'b1;
    end
    @(posedge clk); #1;
    src_valid = 1'b0;
    check("push_accepted", 32'(done), 32'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    enable = 1'b0;
    check("drain_done", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    bit got;
    rst = 1'b1; enable = 1'b0; src_valid = 1'b0; src_data = '0; fir_rfd = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_src_ready", 32'(src_ready), 32'd0);
    check("rst_fir_nd", 32'(fir_nd), 32'd0);
    check("rst_fir_din", 32'(fir_din), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_underrun", 32'(underrun_cnt), 32'd0);
    check("rst_late", 32'(late_cnt), 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("ready_after_rst", 32'(src_ready), 32'd1);

    // Pacing with rfd low: first tick underruns, the other five are late.
    @(posedge clk); #1; enable = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      check("pace_tick", 32'(sample_tick),
            32'(i == 4 || i == 7 || i == 10 || i == 14 || i == 17 || i == 20));
    end
    @(posedge clk); #1; enable = 1'b0;
    @(negedge clk);
    check("pace_underrun", 32'(underrun_cnt), 32'd1);
    check("pace_late", 32'(late_cnt), 32'd5);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;

    // Ordered delivery.
    fir_rfd = 1'b1;
    for (int d = 1; d <= 8; d++) push(16'(d));
    enable = 1'b1;
    drain();
    @(negedge clk);
    check("ord_underrun", 32'(underrun_cnt), 32'd0);
    check("ord_level", 32'(fifo_level), 32'd0);

    // Full FIFO and backpressure on a ninth sample.
    @(posedge clk); #1;
    for (int d = 8'h11; d <= 8'h18; d++) push(16'(d));
    @(negedge clk);
    check("full_level", 32'(fifo_level), 32'd8);
    check("full_ready", 32'(src_ready), 32'd0);
    @(posedge clk); #1; src_data = 16'h0019; src_valid = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("held_ready", 32'(src_ready), 32'd0);
    check("held_level", 32'(fifo_level), 32'd8);
    @(posedge clk); #1; enable = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (src_ready) got = 1'b1;
    end
    @(posedge clk); #1; src_valid = 1'b0;
    check("ninth_accepted", 32'(got), 32'd1);
    drain();
    @(negedge clk);
    check("full_underrun", 32'(underrun_cnt), 32'd0);

    // Underrun: three ticks from an empty FIFO deliver zeros.
    @(posedge clk); #1;
    repeat (3) exp_q.push_back(16'h0000);
    enable = 1'b1;
    drain();
    @(negedge clk);
    check("underrun_cnt", 32'(underrun_cnt), 32'd3);

    // rfd stall across two ticks.
    @(posedge clk); #1; fir_rfd = 1'b0;
    push(16'hA5A5);
    enable = 1'b1;
    t = 0;
    for (int n = 1; n <= 100 && t < 2; n++) begin
      @(negedge clk);
      if (n >= 2 && sample_tick) t++;
    end
    check("stall_ticks_seen", 32'(t), 32'd2);
    @(posedge clk); #1; fir_rfd = 1'b1;
    @(negedge clk);
    check("stall_nd_early", 32'(fir_nd), 32'd0);
    @(negedge clk);
    check("stall_nd", 32'(fir_nd), 32'd1);
    @(posedge clk); #1; enable = 1'b0;
    @(negedge clk);
    check("stall_late", 32'(late_cnt), 32'd1);
    check("stall_underrun", 32'(underrun_cnt), 32'd3);

    // Reset mid-stream with four samples queued.
    @(posedge clk); #1;
    for (int d = 8'h31; d <= 8'h34; d++) push(16'(d));
    @(negedge clk);
    check("mid_level_before", 32'(fifo_level), 32'd4);
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    check("mid_nd_during", 32'(fir_nd), 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("mid_level", 32'(fifo_level), 32'd0);
    check("mid_underrun", 32'(underrun_cnt), 32'd0);
    check("mid_late", 32'(late_cnt), 32'd0);
    check("mid_nd_after", 32'(fir_nd), 32'd0);
    @(negedge clk);
    check("mid_ready", 32'(src_ready), 32'd1);
    check("mid_nd_after2", 32'(fir_nd), 32'd0);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
